// File: rtl/gpu_cpu_bridge.sv
// CPU-to-GPU register bridge: oversamples an asynchronous CPU bus, decodes the
// register file and queues VRAM writes through a 4-entry FIFO.
module gpu_cpu_bridge (
    input  logic        CLK100MHz,
    input  logic        rst,
    input  logic        cpu_clk,
    input  logic        cs,
    input  logic        rw,
    input  logic [2:0]  addr,
    input  logic [7:0]  data_in,
    output logic [7:0]  data_out,
    output logic        data_oe,
    output logic        vram_req,
    output logic [15:0] vram_addr,
    output logic [7:0]  vram_wdata,
    input  logic        vram_ready,
    input  logic        vblank,
    output logic        display_en
);

    localparam logic [2:0] A_ADDR_LO = 3'd0;
    localparam logic [2:0] A_ADDR_HI = 3'd1;
    localparam logic [2:0] A_DATA    = 3'd2;
    localparam logic [2:0] A_INCR    = 3'd3;
    localparam logic [2:0] A_CONTROL = 3'd4;
    localparam logic [2:0] A_STATUS  = 3'd5;

    // {cpu_clk, cs, rw, addr, data_in}
    logic [13:0] bus_s1, bus_s2;
    logic        clk_d3;

    logic       clk_s2, cs_s2, rw_s2;
    logic [2:0] addr_s2;
    logic [7:0] data_s2;
    assign {clk_s2, cs_s2, rw_s2, addr_s2, data_s2} = bus_s2;

    logic [15:0] ptr;
    logic [7:0]  incr;
    logic [7:0]  control;
    logic        ovf;

    logic [23:0] fifo_mem [4];
    logic [1:0]  wr_idx, rd_idx;
    logic [2:0]  count;

    logic cycle_end, wr_en, push_req, push, pop, drop, full, empty, status_rd;

    assign cycle_end = clk_d3 && !clk_s2;
    assign wr_en     = cycle_end && !cs_s2 && !rw_s2;
    assign status_rd = cycle_end && !cs_s2 && rw_s2 && (addr_s2 == A_STATUS);
    assign push_req  = wr_en && (addr_s2 == A_DATA);
    assign full      = (count == 3'd4);
    assign empty     = (count == 3'd0);
    assign pop       = !empty && vram_ready;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign push      = push_req && (!full || pop);
    assign drop      = push_req && full && !pop;

    assign vram_req   = !empty;
    assign vram_addr  = fifo_mem[rd_idx][23:8];
    assign vram_wdata = fifo_mem[rd_idx][7:0];
    assign display_en = control[0];
    assign data_oe    = !cs_s2 && rw_s2 && clk_s2;

    always_comb begin
        data_out = 8'h00;
        if (data_oe) begin
            case (addr_s2)
                A_ADDR_LO: data_out = ptr[7:0];
                A_ADDR_HI: data_out = ptr[15:8];
                A_INCR:    data_out = incr;
                A_CONTROL: data_out = control;
                A_STATUS:  data_out = {4'b0000, vblank, ovf, empty, full};
                default:   data_out = 8'h00;
            endcase
        end
    end

    always_ff @(posedge CLK100MHz) begin
        if (rst) begin
            bus_s1  <= '0;
            bus_s2  <= '0;
            clk_d3  <= 1'b0;
            ptr     <= 16'h0000;
            incr    <= 8'h01;
            control <= 8'h00;
            ovf     <= 1'b0;
            wr_idx  <= 2'd0;
            rd_idx  <= 2'd0;
            count   <= 3'd0;
        end else begin
            bus_s1 <= {cpu_clk, cs, rw, addr, data_in};
            bus_s2 <= bus_s1;
            clk_d3 <= clk_s2;

            if (wr_en) begin
                case (addr_s2)
                    A_ADDR_LO: ptr[7:0]  <= data_s2;
                    A_ADDR_HI: ptr[15:8] <= data_s2;
                    A_DATA:    ptr       <= ptr + {8'h00, incr};
                    A_INCR:    incr      <= data_s2;
                    A_CONTROL: control   <= data_s2;
                    default:   ;
                endcase
            end

            if (push) begin
                fifo_mem[wr_idx] <= {ptr, data_s2};
                wr_idx           <= wr_idx + 2'd1;
            end
            if (pop)
                rd_idx <= rd_idx + 2'd1;
            case ({push, pop})
                2'b10:   count <= count + 3'd1;
                2'b01:   count <= count - 3'd1;
                default: ;
            endcase

            // A drop in the same cycle as the STATUS read wins.
            if (drop)
                ovf <= 1'b1;
            else if (status_rd)
                ovf <= 1'b0;
        end
    end

endmodule
